// File: rtl/commit_unit.sv
// Commit unit: tracks pending/done/exception state per ROB entry, retires
// the head entry in order, and converts exceptions or memory-order
// violations into a one-cycle flush followed by a timed dispatch stall.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | normal in-order retirement
// DRAIN   | violation recorded; retire up to (not including) viol_q
// FLUSH   | one-cycle flush pulse; all entries invalidated
// RECOVER | dispatch stalled while the down-counter runs out
module commit_unit #(
   parameter int ROB_SIZE       = 16,
   parameter int ROB_SEL        = 4,
   parameter int RECOVER_CYCLES = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               alloc_valid,
   input  logic [ROB_SEL-1:0] alloc_idx,
   input  logic               wb_valid,
   input  logic [ROB_SEL-1:0] wb_idx,
   input  logic               wb_exception,
   input  logic               violation_valid,
   input  logic [ROB_SEL-1:0] violation_idx,
   output logic               commit_enable,
   output logic [ROB_SEL-1:0] commit_rob_idx,
   output logic               flush,
   output logic [ROB_SEL-1:0] flush_idx,
   output logic               stall,
   output logic               busy
);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FLUSH, S_RECOVER} state_t;

   state_t              r_state;
   logic [ROB_SIZE-1:0] r_pend;
   logic [ROB_SIZE-1:0] r_done;
   logic [ROB_SIZE-1:0] r_exc;
   logic [ROB_SEL-1:0]  r_head;
   logic [ROB_SEL-1:0]  r_viol_q;
   logic [3:0]          r_cnt;

   logic                w_active;
   logic                w_head_ready;
   logic                w_head_exc;
   logic                w_drain_hit;
   logic                w_go_flush;
   logic                w_viol_ok;
   logic [ROB_SEL-1:0]  w_viol_age;
   logic [ROB_SEL-1:0]  w_held_age;
   logic                w_retire;
   logic                w_wb_ok;
   logic [ROB_SIZE-1:0] w_pend_nxt;
   logic [ROB_SIZE-1:0] w_done_nxt;
   logic [ROB_SIZE-1:0] w_exc_nxt;

   assign w_active     = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign w_head_ready = r_pend[r_head] & r_done[r_head];
   assign w_head_exc   = w_head_ready & r_exc[r_head];
   assign w_drain_hit  = (r_state == S_DRAIN) && (r_head == r_viol_q);
   assign w_go_flush   = w_active & (w_head_exc | w_drain_hit);
   assign w_viol_ok    = violation_valid & r_pend[violation_idx];
   // Age is distance from head, so modulo wrap orders entries correctly.
   assign w_viol_age   = violation_idx - r_head;
   assign w_held_age   = r_viol_q - r_head;
   // A violating load must never retire, even on the edge it is reported.
   assign w_retire     = w_active & ~w_go_flush & w_head_ready &
                         ~(w_viol_ok && (violation_idx == r_head));
   assign w_wb_ok      = wb_valid & r_pend[wb_idx] &
                         ~(alloc_valid && (alloc_idx == wb_idx));
   assign busy         = (r_state != S_RUN);

   // Next per-entry bits: writeback, then retire clear, then allocation.
   always_comb begin
      w_pend_nxt = r_pend;
      w_done_nxt = r_done;
      w_exc_nxt  = r_exc;
      if (w_go_flush) begin
         w_pend_nxt = '0;
         w_done_nxt = '0;
         w_exc_nxt  = '0;
      end else if (w_active) begin
         if (w_wb_ok) begin
            w_done_nxt[wb_idx] = 1'b1;
            w_exc_nxt[wb_idx]  = wb_exception;
         end
         if (w_retire) begin
            w_pend_nxt[r_head] = 1'b0;
            w_done_nxt[r_head] = 1'b0;
         end
         if (alloc_valid && !stall) begin
            w_pend_nxt[alloc_idx] = 1'b1;
            w_done_nxt[alloc_idx] = 1'b0;
            w_exc_nxt[alloc_idx]  = 1'b0;
         end
      end
   end

   // Commit FSM with registered outputs and entry-state update.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_RUN;
         r_pend         <= '0;
         r_done         <= '0;
         r_exc          <= '0;
         r_head         <= '0;
         r_viol_q       <= '0;
         r_cnt          <= '0;
         commit_enable  <= 1'b0;
         commit_rob_idx <= '0;
         flush          <= 1'b0;
         flush_idx      <= '0;
         stall          <= 1'b0;
      end else begin
         r_pend <= w_pend_nxt;
         r_done <= w_done_nxt;
         r_exc  <= w_exc_nxt;
         case (r_state)
            S_RUN, S_DRAIN: begin
               if (w_go_flush) begin
                  r_state       <= S_FLUSH;
                  flush         <= 1'b1;
                  flush_idx     <= r_head;
                  stall         <= 1'b1;
                  commit_enable <= 1'b0;
               end else begin
                  flush         <= 1'b0;
                  commit_enable <= w_retire;
                  if (w_retire) begin
                     commit_rob_idx <= r_head;
                     r_head         <= r_head + 1'b1;
                  end
                  if (w_viol_ok) begin
                     r_state <= S_DRAIN;
                     if ((r_state == S_RUN) || (w_viol_age < w_held_age))
                        r_viol_q <= violation_idx;
                  end
               end
            end
            S_FLUSH: begin
               flush         <= 1'b0;
               commit_enable <= 1'b0;
               r_cnt         <= 4'(RECOVER_CYCLES - 1);
               r_state       <= S_RECOVER;
            end
            S_RECOVER: begin
               commit_enable <= 1'b0;
               if (r_cnt == 4'd0) begin
                  r_state <= S_RUN;
                  stall   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_commit_unit.sv
// Bench for commit_unit: directed scenarios followed by random traffic,
// all compared cycle by cycle against an abstract ROB model.
module tb_commit_unit;

   localparam int RS  = 16;
   localparam int SEL = 4;
   localparam int RC  = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic           alloc_valid;
   logic [SEL-1:0] alloc_idx;
   logic           wb_valid;
   logic [SEL-1:0] wb_idx;
   logic           wb_exception;
   logic           violation_valid;
   logic [SEL-1:0] violation_idx;
   logic           commit_enable;
   logic [SEL-1:0] commit_rob_idx;
   logic           flush;
   logic [SEL-1:0] flush_idx;
   logic           stall;
   logic           busy;

   commit_unit #(.ROB_SIZE(RS), .ROB_SEL(SEL), .RECOVER_CYCLES(RC)) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
      .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_exception(wb_exception),
      .violation_valid(violation_valid), .violation_idx(violation_idx),
      .commit_enable(commit_enable), .commit_rob_idx(commit_rob_idx),
      .flush(flush), .flush_idx(flush_idx), .stall(stall), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: plain arrays, a head counter, and a stall countdown.
   bit m_pend[RS];
   bit m_done[RS];
   bit m_exc[RS];
   int m_head, m_viol, m_stall_left;
   bit m_drain, m_stalled, m_retired, m_flushed;
   bit e_ce, e_fl, e_stall;
   int e_cidx, e_fidx;

   int log_q[$];
   int n_flush, n_stall_hi, last_fidx;

   function automatic int age(input int i);
      return (i - m_head + RS) % RS;
   endfunction

   task automatic clear_entries();
      for (int i = 0; i < RS; i++) begin
         m_pend[i] = 0; m_done[i] = 0; m_exc[i] = 0;
      end
   endtask

   task automatic model_step();
      bit hd_ok, vok, retire;
      m_retired = 0;
      m_flushed = 0;
      if (reset) begin
         clear_entries();
         m_head = 0; m_viol = 0; m_drain = 0; m_stalled = 0; m_stall_left = 0;
         e_ce = 0; e_cidx = 0; e_fl = 0; e_fidx = 0; e_stall = 0;
      end else if (m_stalled) begin
         e_fl = 0;
         e_ce = 0;
         m_stall_left--;
         if (m_stall_left == 0) begin
            m_stalled = 0;
            e_stall = 0;
         end
      end else begin
         hd_ok = m_pend[m_head] && m_done[m_head];
         vok   = violation_valid && m_pend[violation_idx];
         if ((hd_ok && m_exc[m_head]) || (m_drain && m_head == m_viol)) begin
            e_fl = 1; e_fidx = m_head; e_ce = 0; e_stall = 1;
            m_stalled = 1; m_drain = 0; m_stall_left = RC + 1;
            m_flushed = 1;
            clear_entries();
         end else begin
            retire = hd_ok && !(vok && int'(violation_idx) == m_head);
            if (vok) begin
               if (!m_drain || age(int'(violation_idx)) < age(m_viol))
                  m_viol = int'(violation_idx);
               m_drain = 1;
            end
            if (wb_valid && m_pend[wb_idx] && !(alloc_valid && alloc_idx == wb_idx)) begin
               m_done[wb_idx] = 1;
               m_exc[wb_idx]  = wb_exception;
            end
            e_fl = 0;
            e_ce = retire;
            if (retire) begin
               e_cidx = m_head;
               m_pend[m_head] = 0;
               m_done[m_head] = 0;
               m_head = (m_head + 1) % RS;
               m_retired = 1;
            end
            if (alloc_valid) begin
               m_pend[alloc_idx] = 1;
               m_done[alloc_idx] = 0;
               m_exc[alloc_idx]  = 0;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      alloc_valid = 0; alloc_idx = '0;
      wb_valid = 0; wb_idx = '0; wb_exception = 0;
      violation_valid = 0; violation_idx = '0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("commit_enable", commit_enable, e_ce);
      chk("commit_rob_idx", commit_rob_idx, e_cidx);
      chk("flush", flush, e_fl);
      chk("flush_idx", flush_idx, e_fidx);
      chk("stall", stall, e_stall);
      chk("busy", busy, m_drain || m_stalled);
      if (commit_enable === 1'b1) log_q.push_back(int'(commit_rob_idx));
      if (flush === 1'b1) begin n_flush++; last_fidx = int'(flush_idx); end
      if (stall === 1'b1) n_stall_hi++;
   endtask

   task automatic idle(input int n);
      clr_in();
      repeat (n) tick();
   endtask

   task automatic do_alloc(input int idx);
      clr_in(); alloc_valid = 1; alloc_idx = 4'(idx); tick();
   endtask

   task automatic do_wb(input int idx, input bit ex);
      clr_in(); wb_valid = 1; wb_idx = 4'(idx); wb_exception = ex; tick();
   endtask

   task automatic do_viol(input int idx);
      clr_in(); violation_valid = 1; violation_idx = 4'(idx); tick();
   endtask

   task automatic do_reset();
      clr_in(); reset = 1; tick(); reset = 0;
   endtask

   task automatic start_scn();
      log_q.delete(); n_flush = 0; n_stall_hi = 0; last_fidx = -1;
   endtask

   // Commits seen must be n consecutive indices starting at first.
   task automatic chk_commits(input string tag, input int n, input int first);
      chk({tag, "_count"}, log_q.size(), n);
      for (int i = 0; i < n; i++)
         if (i < log_q.size()) chk({tag, "_idx"}, log_q[i], (first + i) % RS);
   endtask

   initial begin
      int tail, count, acc;
      clr_in();
      reset = 1;
      tick(); tick();
      reset = 0;
      chk("rst_stall", stall, 0);
      chk("rst_busy", busy, 0);

      // In-order retirement from out-of-order writeback.
      start_scn();
      for (int i = 0; i < 4; i++) do_alloc(i);
      for (int i = 0; i < 4; i++) do_wb(3 - i, 0);
      idle(6);
      chk_commits("s1", 4, 0);

      // Walk head to 14, then retire across the wrap.
      for (int h = 4; h < 14; h++) begin
         do_alloc(h); do_wb(h, 0); idle(1);
      end
      start_scn();
      do_alloc(14); do_alloc(15); do_alloc(0); do_alloc(1);
      do_wb(14, 0); do_wb(15, 0); do_wb(0, 0); do_wb(1, 0);
      idle(6);
      chk_commits("s2", 4, 14);
      start_scn();
      do_alloc(2); do_wb(2, 0); idle(3);
      chk_commits("s2_head", 1, 2);

      // Violation drains older entries, then flushes at the load.
      do_reset();
      start_scn();
      for (int i = 0; i < 5; i++) do_alloc(i);
      do_viol(2);
      for (int i = 0; i < 5; i++) do_wb(i, 0);
      idle(8);
      chk_commits("s3", 2, 0);
      chk("s3_flushes", n_flush, 1);
      chk("s3_flush_idx", last_fidx, 2);
      chk("s3_stall_cycles", n_stall_hi, 1 + RC);

      // A younger violation in DRAIN is replaced by an older one.
      do_reset();
      for (int i = 0; i < 5; i++) do_alloc(i);
      start_scn();
      do_wb(0, 0); idle(1);
      do_viol(3); do_viol(2);
      do_wb(1, 0);
      idle(8);
      chk_commits("s4", 2, 0);
      chk("s4_flushes", n_flush, 1);
      chk("s4_flush_idx", last_fidx, 2);

      // Exception at head flushes without committing and clears entries.
      do_reset();
      start_scn();
      do_alloc(0); do_wb(0, 1);
      idle(8);
      do_wb(0, 0);
      idle(3);
      chk_commits("s5", 0, 0);
      chk("s5_flushes", n_flush, 1);
      chk("s5_flush_idx", last_fidx, 0);

      // Reset during RECOVER returns to RUN with head at 0.
      do_alloc(0); do_wb(0, 0); idle(2);
      do_alloc(1); do_wb(1, 1);
      idle(3);
      chk("s6_in_recover", busy, 1);
      do_reset();
      chk("s6_stall", stall, 0);
      chk("s6_busy", busy, 0);
      start_scn();
      do_alloc(0); do_wb(0, 0); idle(3);
      chk_commits("s6_head", 1, 0);

      // Random traffic from an in-order dispatcher against the model.
      do_reset();
      tail = 0;
      count = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         clr_in();
         reset = ($urandom % 600 == 0);
         if (count < RS && ($urandom % 3) != 0) begin
            alloc_valid = 1;
            alloc_idx = 4'(tail);
         end
         if ($urandom % 2 == 1) begin
            wb_valid = 1;
            wb_idx = (count > 0) ? 4'((m_head + int'($urandom % count)) % RS) : 4'($urandom % RS);
            wb_exception = ($urandom % 40 == 0);
         end
         if ($urandom % 25 == 0) begin
            violation_valid = 1;
            violation_idx = (count > 0 && $urandom % 2 == 1) ?
                            4'((m_head + int'($urandom % count)) % RS) : 4'($urandom % RS);
         end
         acc = (alloc_valid && !m_stalled && !reset) ? 1 : 0;
         tick();
         if (reset || m_flushed) begin
            count = 0;
            tail = m_head;
         end else begin
            count = count + acc - int'(m_retired);
            tail = (tail + acc) % RS;
         end
      end
      reset = 0;
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
